// File: rtl/flow_quant_mult.sv
// flow_quant_mult: scales N signed coefficient lanes per beat by per-position entries of a
// 64-entry quantisation table, rounds half away from zero, saturates, and carries block sideband.
module flow_quant_mult #(
  parameter int N     = 2,
  parameter int DW    = 16,
  parameter int MW    = 12,
  parameter int SHIFT = 8,
  parameter int OW    = 16,
  parameter int PIPE  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in_valid,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_eob,
  input  logic            in_sob,
  input  logic            in_sof,
  input  logic            tbl_we,
  input  logic [5:0]      tbl_addr,
  input  logic [MW-1:0]   tbl_wdata,
  output logic            out_valid,
  output logic [N*OW-1:0] out_data,
  output logic            out_eob,
  output logic            out_sob,
  output logic            out_sof,
  output logic [N-1:0]    out_sat,
  output logic            out_err
);
  localparam int PW = DW + MW + 1;
  localparam int QW = 1 + 4 + N + N * OW;
  localparam logic [5:0] LAST = 6'(64 - N);
  localparam logic [PW-1:0] HALF = PW'((2 ** SHIFT) / 2);
  localparam logic signed [PW-1:0] OMAX = PW'((2 ** (OW - 1)) - 1);
  localparam logic signed [PW-1:0] OMIN = PW'(-(2 ** (OW - 1)));

  // Flow control: a beat is taken on a cycle with in_valid & en; en = 0 freezes every stage
  // and only the final valid bit drops, so each beat is presented on out_valid exactly once.
  logic [MW-1:0] tbl [64];
  logic [5:0]    pos, base, pos_next;
  logic          accept, frame_err;

  always_comb begin
    accept    = in_valid & en;
    base      = in_sob ? 6'd0 : pos;
    pos_next  = base + 6'(N % 64);
    frame_err = (in_sob && (pos != 6'd0)) || (in_eob && (base != LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos <= 6'd0;
    else if (accept) pos <= in_eob ? 6'd0 : pos_next;
  end

  // Table writes ignore en; a same-edge stage-1 lookup still samples the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) tbl[k] <= '0;
    end else if (tbl_we) begin
      tbl[tbl_addr] <= tbl_wdata;
    end
  end

  logic                 s1_vld;
  logic [3:0]           s1_side;
  logic signed [DW-1:0] s1_data [N];
  logic [MW-1:0]        s1_coef [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_side <= '0;
      for (int i = 0; i < N; i++) begin
        s1_data[i] <= '0;
        s1_coef[i] <= '0;
      end
    end else if (en) begin
      s1_vld  <= in_valid;
      s1_side <= {in_valid & frame_err, in_sof, in_sob, in_eob};
      for (int i = 0; i < N; i++) begin
        s1_data[i] <= in_data[i*DW +: DW];
        s1_coef[i] <= tbl[base + 6'(i)];
      end
    end
  end

  logic                 s2_vld;
  logic [3:0]           s2_side;
  logic signed [PW-1:0] s2_prod [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_side <= '0;
      for (int i = 0; i < N; i++) s2_prod[i] <= '0;
    end else if (en) begin
      s2_vld  <= s1_vld;
      s2_side <= s1_side;
      for (int i = 0; i < N; i++)
        s2_prod[i] <= PW'(s1_data[i]) * PW'($signed({1'b0, s1_coef[i]}));
    end
  end

  // Returns {sat, value}; with SHIFT = 0 HALF is 0 and the magnitude path reproduces p.
  function automatic logic [OW:0] round_sat(input logic signed [PW-1:0] p);
    logic [PW-1:0]        mag;
    logic signed [PW-1:0] r;
    mag = p[PW-1] ? $unsigned(-p) : $unsigned(p);
    mag = (mag + HALF) >> SHIFT;
    r   = p[PW-1] ? -$signed(mag) : $signed(mag);
    if (r > OMAX)      round_sat = {1'b1, OMAX[OW-1:0]};
    else if (r < OMIN) round_sat = {1'b1, OMIN[OW-1:0]};
    else               round_sat = {1'b0, r[OW-1:0]};
  endfunction

  logic [N*OW-1:0] st3_data;
  logic [N-1:0]    st3_sat;
  logic [OW:0]     lane_rs;
  logic [QW-1:0]   st3;
  logic [QW-1:0]   q [3:PIPE];

  always_comb begin
    st3_data = '0;
    st3_sat  = '0;
    lane_rs  = '0;
    for (int i = 0; i < N; i++) begin
      lane_rs                  = round_sat(s2_prod[i]);
      st3_sat[i]               = lane_rs[OW];
      st3_data[i*OW +: OW]     = lane_rs[OW-1:0];
    end
    st3 = {s2_vld, s2_side, st3_sat, st3_data};
  end

  // q[3] is the round/saturate register, q[4..PIPE] pure delay; q[PIPE] drives the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 3; j <= PIPE; j++) q[j] <= '0;
    end else if (en) begin
      q[3] <= st3;
      for (int j = 4; j <= PIPE; j++) q[j] <= q[j-1];
    end else begin
      q[PIPE][QW-1] <= 1'b0;
    end
  end

  assign {out_valid, out_err, out_sof, out_sob, out_eob, out_sat, out_data} = q[PIPE];

endmodule

// File: tb/tb_flow_quant_mult.sv
// Bench for flow_quant_mult: directed vector table, framing/stall/race/reset sequences and a
// randomized run checked against an integer reference model through an expected-value queue.
module tb_flow_quant_mult;
  localparam int N = 2, DW = 16, MW = 12, SHIFT = 8, OW = 16, PIPE = 4;
  localparam int EW = 32 + 4 + N + N * OW;
  localparam int SIDEP = N * OW + N;
  localparam int ACCP  = N * OW + N + 4;

  logic            clk, rst_n, en, in_valid, in_eob, in_sob, in_sof, tbl_we;
  logic [N*DW-1:0] in_data;
  logic [5:0]      tbl_addr;
  logic [MW-1:0]   tbl_wdata;
  logic            out_valid, out_eob, out_sob, out_sof, out_err;
  logic [N*OW-1:0] out_data;
  logic [N-1:0]    out_sat;

  flow_quant_mult #(.N(N), .DW(DW), .MW(MW), .SHIFT(SHIFT), .OW(OW), .PIPE(PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_eob(in_eob), .in_sob(in_sob), .in_sof(in_sof), .tbl_we(tbl_we),
    .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .out_valid(out_valid),
    .out_data(out_data), .out_eob(out_eob), .out_sob(out_sob), .out_sof(out_sof),
    .out_sat(out_sat), .out_err(out_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  int m_tbl [64];
  int m_pos = 0;
  logic [EW-1:0]   exp_q[$];
  logic [N*OW-1:0] log_data[$];
  logic [3:0]      log_side[$];
  logic [N-1:0]    log_sat[$];

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: full-precision product, round half away from zero, clamp to OW bits.
  function automatic longint ref_lane(input longint d, input longint t, output bit s);
    longint p, mag, r, hi, lo;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    p = d * t;
    mag = (p < 0) ? -p : p;
    mag = (mag + (longint'(1) << SHIFT) / 2) / (longint'(1) << SHIFT);
    r = (p < 0) ? -mag : mag;
    s = 1'b0;
    if (r > hi) begin s = 1'b1; r = hi; end
    else if (r < lo) begin s = 1'b1; r = lo; end
    return r;
  endfunction

  function automatic logic [N*DW-1:0] lanes(input int a, input int b);
    return {DW'(b), DW'(a)};
  endfunction

  // reference model: acceptance, position tracking, table image
  always @(posedge clk or negedge rst_n) begin : model
    int base;
    bit err, s;
    logic [N*OW-1:0] d;
    logic [N-1:0] sv;
    longint v;
    if (!rst_n) begin
      exp_q.delete();
      m_pos = 0;
      foreach (m_tbl[k]) m_tbl[k] = 0;
    end else begin
      if (en) en_cnt++;
      if (en && in_valid) begin
        base = in_sob ? 0 : m_pos;
        err = (in_sob && m_pos != 0) || (in_eob && base != 64 - N);
        for (int i = 0; i < N; i++) begin
          v = ref_lane(longint'($signed(in_data[i*DW +: DW])), m_tbl[(base + i) % 64], s);
          d[i*OW +: OW] = OW'(v);
          sv[i] = s;
        end
        exp_q.push_back({32'(en_cnt), err, in_sof, in_sob, in_eob, sv, d});
        m_pos = in_eob ? 0 : (base + N) % 64;
      end
      if (tbl_we) m_tbl[tbl_addr] = int'(tbl_wdata);
    end
  end

  // scoreboard / output log
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (rst_n && out_valid) begin
      log_data.push_back(out_data);
      log_side.push_back({out_err, out_sof, out_sob, out_eob});
      log_sat.push_back(out_sat);
      if (exp_q.size() == 0) begin
        chk("sb_spurious_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < N; i++)
          chk("sb_lane", $signed(out_data[i*OW +: OW]), $signed(e[i*OW +: OW]));
        chk("sb_sat", out_sat, e[N*OW +: N]);
        chk("sb_side", {out_err, out_sof, out_sob, out_eob}, e[SIDEP +: 4]);
        chk("sb_latency", en_cnt - int'(e[ACCP +: 32]), PIPE - 1);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [N*DW-1:0] d, input logic sob, input logic eob,
                       input logic we, input logic [5:0] a, input logic [MW-1:0] w);
    @(negedge clk);
    in_valid = v; in_data = d; in_sob = sob; in_eob = eob; in_sof = sob;
    tbl_we = we; tbl_addr = a; tbl_wdata = w;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
  endtask

  task automatic twrite(input int a, input int w);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 6'(a), MW'(w));
  endtask

  task automatic beat(input logic [N*DW-1:0] d, input logic sob, input logic eob);
    drive(1'b1, d, sob, eob, 1'b0, 6'd0, '0);
  endtask

  task automatic clear_log();
    log_data.delete(); log_side.delete(); log_sat.delete();
  endtask

  function automatic longint lane_of(input int k, input int i);
    logic [N*OW-1:0] w;
    w = log_data[k];
    return longint'($signed(w[i*OW +: OW]));
  endfunction

  typedef struct { int t0; int t1; int d0; int d1; int e0; int e1; int s; } vec_t;
  vec_t vecs [10];

  initial begin
    logic [N*DW-1:0] sd [10];
    bit s;
    longint ev;
    int eob_at, err_cnt;

    vecs[0] = '{128, 128, 100, 101, 50, 51, 0};
    vecs[1] = '{128, 128, -101, -100, -51, -50, 0};
    vecs[2] = '{4095, 4095, 32767, -32768, 32767, -32768, 3};
    vecs[3] = '{4095, 4095, 0, 1, 0, 16, 0};
    vecs[4] = '{1, 1, 128, -128, 1, -1, 0};
    vecs[5] = '{1, 1, 127, -127, 0, 0, 0};
    vecs[6] = '{4095, 4095, 2049, -2049, 32767, -32768, 3};
    vecs[7] = '{4095, 4095, 2048, -2048, 32760, -32760, 0};
    vecs[8] = '{256, 256, 32767, -32768, 32767, -32768, 0};
    vecs[9] = '{257, 257, -32768, 32767, -32768, 32767, 3};

    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; in_sob = 1'b0; in_eob = 1'b0;
    in_sof = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_sat", out_sat, 0);
    chk("reset_out_side", {out_err, out_sof, out_sob, out_eob}, 0);
    rst_n = 1'b1; en = 1'b1;
    idle(2);

    // directed vector table on positions 0/1
    for (int v = 0; v < 10; v++) begin
      twrite(0, vecs[v].t0);
      twrite(1, vecs[v].t1);
      clear_log();
      beat(lanes(vecs[v].d0, vecs[v].d1), 1'b1, 1'b0);
      idle(6);
      chk($sformatf("vec%0d_count", v), log_data.size(), 1);
      if (log_data.size() >= 1) begin
        chk($sformatf("vec%0d_lane0", v), lane_of(0, 0), vecs[v].e0);
        chk($sformatf("vec%0d_lane1", v), lane_of(0, 1), vecs[v].e1);
        chk($sformatf("vec%0d_sat", v), log_sat[0], vecs[v].s);
        chk($sformatf("vec%0d_sob", v), log_side[0][1], 1);
      end
    end

    // positional lookup over a full 32-beat block
    beat('0, 1'b0, 1'b1);
    for (int k = 0; k < 64; k++) twrite(k, k + 1);
    idle(4);
    clear_log();
    for (int b = 0; b < 32; b++) beat(lanes(256, 256), b == 0, b == 31);
    idle(6);
    chk("pos_count", log_data.size(), 32);
    eob_at = -1; err_cnt = 0;
    for (int b = 0; b < log_data.size(); b++) begin
      chk($sformatf("pos_b%0d_lane0", b), lane_of(b, 0), 2 * b + 1);
      chk($sformatf("pos_b%0d_lane1", b), lane_of(b, 1), 2 * b + 2);
      if (log_side[b][0]) eob_at = b;
      if (log_side[b][3]) err_cnt++;
    end
    chk("pos_eob_beat", eob_at, 31);
    chk("pos_err_count", err_cnt, 0);

    // early eob on beat 20, then a fresh sob must not see a stale position
    clear_log();
    for (int b = 0; b <= 20; b++) beat(lanes(256, 256), b == 0, b == 20);
    beat(lanes(256, 256), 1'b1, 1'b0);
    idle(6);
    chk("early_count", log_data.size(), 22);
    if (log_data.size() == 22) begin
      chk("early_err_b19", log_side[19][3], 0);
      chk("early_err_b20", log_side[20][3], 1);
      chk("early_err_next", log_side[21][3], 0);
      chk("early_next_lane0", lane_of(21, 0), 1);
    end

    // stall: en low for 3 cycles mid-stream
    clear_log();
    for (int b = 0; b < 10; b++) begin
      sd[b] = N*DW'($urandom);
      beat(sd[b], b == 0, 1'b0);
      if (b == 5) begin
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
      end
    end
    idle(6);
    chk("stall_count", log_data.size(), 10);
    for (int b = 0; b < 10 && b < log_data.size(); b++) begin
      ev = ref_lane(longint'($signed(sd[b][DW-1:0])), 2 * b + 1, s);
      chk($sformatf("stall_b%0d_lane0", b), lane_of(b, 0), ev);
    end

    // table write in the same cycle as an sob beat
    beat('0, 1'b0, 1'b1);
    idle(6);
    twrite(0, 10);
    clear_log();
    drive(1'b1, lanes(100, 0), 1'b1, 1'b0, 1'b1, 6'd0, MW'(64));
    beat(lanes(100, 0), 1'b1, 1'b1);
    idle(6);
    chk("race_count", log_data.size(), 2);
    if (log_data.size() == 2) begin
      chk("race_old_value", lane_of(0, 0), 4);
      chk("race_new_value", lane_of(1, 0), 25);
    end

    // reset mid-block
    beat(lanes(100, 100), 1'b1, 1'b0);
    beat(lanes(100, 100), 1'b0, 1'b0);
    beat(lanes(100, 100), 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_valid", out_valid, 0);
    chk("midreset_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    clear_log();
    beat(lanes(100, 100), 1'b1, 1'b0);
    idle(6);
    chk("postreset_count", log_data.size(), 1);
    if (log_data.size() == 1) begin
      chk("postreset_lane0", lane_of(0, 0), 0);
      chk("postreset_err", log_side[0][3], 0);
    end

    // randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, N*DW'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            6'($urandom_range(0, 63)), MW'($urandom));
      en = $urandom_range(0, 4) != 0;
    end
    en = 1'b1;
    idle(1);
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) idle(1);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flow_quant_mult.md
Name: flow_quant_mult

Overview:
- Parametrised successor to the flow-pipeline multiplier stage: scales N coefficient lanes per beat by per-position factors from an internal 64-entry quantisation table.
- Applies round-half-away-from-zero right shift, then saturates to the output width.
- Sits after the DCT flow stage. Forwards eob/sob/sof sideband aligned with data. Flags saturation per lane and malformed blocks.

Parameters:
- N, 2, lanes per beat; 64 % N == 0 (1, 2, 4, 8)
- DW, 16, signed input coefficient width
- MW, 12, unsigned table entry width
- SHIFT, 8, product right shift (0 = no rounding)
- OW, 16, signed output width
- PIPE, 4, total latency in enabled cycles; PIPE >= 3

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global pipeline advance; 0 = stall
- in_valid  in  1  input beat valid
- in_data  in  N x DW  signed coefficients; lane i is position base+i
- in_eob / in_sob / in_sof  in  1 each  end/start of block, start of frame
- tbl_we  in  1  table write strobe
- tbl_addr  in  6  table entry index (zigzag position)
- tbl_wdata  in  MW  unsigned table value
- out_valid  out  1  output beat valid
- out_data  out  N x OW  signed results
- out_eob / out_sob / out_sof  out  1 each  sideband delayed with data
- out_sat  out  N  per-lane saturation flag, aligned with out_data
- out_err  out  1  block-framing error, aligned with the offending beat

Behaviour:
- Reset (async, rst_n=0):
  - All pipeline regs, out_* and the position counter clear to 0.
  - All 64 table entries clear to 0.
- Accepted beat: in_valid & en.
- Position counter pos, range 0..64-N, step N:
  - Accepted beat with in_sob: base = 0.
  - Other accepted beats: base = pos.
  - After an accepted beat: pos = base+N, wrapping mod 64. If in_eob, pos = 0.
- Framing error: set on the beat when it arrives and propagates with it.
  - Case A: in_sob while pos != 0.
  - Case B: in_eob while base != 64-N.
- Table:
  - A write on tbl_we takes effect at the clock edge.
  - Stage-1 lookup in the same cycle still reads the old value; lookups from the next cycle see the new value.
  - Writes are independent of en.
- Stage 1: register lanes, sideband, and table[base+i] per lane.
- Stage 2: signed product p = data × {0, tbl}, width DW+MW+1.
- Stage 3, round:
  - r = sign(p) × ((|p| + 2^(SHIFT-1)) >> SHIFT).
  - For SHIFT = 0, r = p.
- Stage 3, saturate:
  - r > 2^(OW-1)-1 → max, sat = 1.
  - r < -2^(OW-1) → min, sat = 1.
  - Otherwise sat = 0.
- Stages 4..PIPE: pure delay registers.
- Stall (en = 0):
  - All data, sideband and table-lookup regs hold.
  - Final valid register loads 0, so each beat appears on out_valid for exactly one cycle.
  - Bubbles (in_valid = 0 with en = 1) propagate as out_valid = 0.
- Latency: a beat accepted at enabled cycle k is output after PIPE enabled cycles. Stall cycles extend latency one-for-one.
- Output gating: out_data, out_sat, sideband and out_err are meaningful only when out_valid = 1; they are held otherwise.
- Reset mid-operation: all in-flight beats are discarded and pos returns to 0. The table must be reloaded.
- Simultaneous in_sob and in_eob on one beat: legal only for N = 64. For N < 64 it raises out_err via Case B.

Test Plan:
- Rounding: N=2, table[0]=table[1]=128, SHIFT=8. Beat sob, data {100, 101} → after 4 enabled cycles out_data {50, 51}, out_sat 0, out_sob 1.
- Negative rounding: same table, data {-101, -100} → {-51, -50}. Round half away from zero.
- Saturation: table[0]=4095. Data 32767 → 32767, sat 1. Data -32768 → -32768, sat 1. Data 0 → 0, sat 0.
- Positional lookup:
  - Stimulus: table[k] = k+1, then a full 32-beat block (sob on beat 0, eob on beat 31), all data 256.
  - Required: lane values equal position+1 in order 1..64; out_err 0; out_eob on beat 31.
  - Follow-on: an eob sent on beat 20 instead gives out_err 1 on that beat, and pos = 0 afterwards.
- Stall: toggle en 0 for 3 cycles mid-stream.
  - Every input beat appears once, in order, with no duplicates.
  - Latency measured in enabled cycles stays 4.
- Table write race and reset:
  - Write table[0]=64 in the same cycle as an sob beat; that beat uses the old value, the next block's beat uses 64.
  - Assert rst_n mid-block: out_valid 0 immediately, and the table reads 0.
